// File: rtl/pilha_sequenciador_if.sv
// pilha_sequenciador_if: instruction valid/ready handshake between the UC fetch logic
// (master) and the stack sequencer (slave). instr = {kind[22:21], op[20:16], imm[15:0]}.
interface pilha_sequenciador_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [22:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/pilha_sequenciador.sv
// pilha_sequenciador: sequences push/pop/temp-load strobes for the stack/ULA datapath.
// Optional macro PILHA_SEQ_TRAP_EN: an illegal instruction parks the FSM in TRAP until reset.
module pilha_sequenciador #(
    parameter  int STACK_DEPTH = 16,
    parameter  int DATA_W      = 16,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    pilha_sequenciador_if.slave instr_if,
    input  logic [DATA_W-1:0]   dout_dp,
    output logic [DATA_W-1:0]   din_UC,
    output logic [4:0]          opcode,
    output logic                push,
    output logic                pop,
    output logic                controle_pilha,
    output logic                load_temp1,
    output logic                load_temp2,
    output logic                clk_pilha,
    output logic                clk_temp1,
    output logic                clk_temp2,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid,
    output logic [DEPTH_W-1:0]  depth,
    output logic                error
);

    typedef enum logic [1:0] {
        K_PUSH   = 2'b00,
        K_BINARY = 2'b01,
        K_UNARY  = 2'b10,
        K_POP    = 2'b11
    } kind_e;

    typedef enum logic [3:0] {
        S_IDLE, S_T1_SET, S_T1_CLK, S_T1_LD, S_T2_SET, S_T2_CLK, S_T2_LD,
        S_RES_SET, S_RES_CLK, S_PUSH_SET, S_PUSH_CLK, S_POP_SET, S_POP_CLK,
        S_DONE, S_TRAP
    } state_e;

    typedef struct packed {
        logic instr_ready;
        logic push;
        logic pop;
        logic controle_pilha;
        logic load_temp1;
        logic load_temp2;
        logic clk_pilha;
        logic clk_temp1;
        logic clk_temp2;
        logic done;
    } ctrl_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);

    state_e state;
    state_e nxt;
    kind_e  kind;
    ctrl_t  ctrl;
    kind_e  instr_kind;
    logic   accept;
    logic   legal;

    // Control levels for the cycle spent in state s; registered one edge ahead.
    function automatic ctrl_t ctrl_of(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IDLE:     c.instr_ready = 1'b1;
            S_T1_SET:   begin c.pop = 1'b1; c.load_temp1 = 1'b1; end
            S_T1_CLK:   begin c.pop = 1'b1; c.load_temp1 = 1'b1; c.clk_pilha = 1'b1; end
            S_T1_LD:    begin c.load_temp1 = 1'b1; c.clk_temp1 = 1'b1; end
            S_T2_SET:   begin c.pop = 1'b1; c.load_temp2 = 1'b1; end
            S_T2_CLK:   begin c.pop = 1'b1; c.load_temp2 = 1'b1; c.clk_pilha = 1'b1; end
            S_T2_LD:    begin c.load_temp2 = 1'b1; c.clk_temp2 = 1'b1; end
            S_RES_SET:  begin c.push = 1'b1; c.controle_pilha = 1'b1; end
            S_RES_CLK:  begin c.push = 1'b1; c.controle_pilha = 1'b1; c.clk_pilha = 1'b1; end
            S_PUSH_SET: c.push = 1'b1;
            S_PUSH_CLK: begin c.push = 1'b1; c.clk_pilha = 1'b1; end
            S_POP_SET:  c.pop = 1'b1;
            S_POP_CLK:  begin c.pop = 1'b1; c.clk_pilha = 1'b1; end
            S_DONE:     c.done = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic state_e first_of(input kind_e k);
        case (k)
            K_PUSH:  return S_PUSH_SET;
            K_POP:   return S_POP_SET;
            default: return S_T1_SET;
        endcase
    endfunction

    function automatic state_e advance(input state_e s, input kind_e k);
        case (s)
            S_T1_SET:   return S_T1_CLK;
            S_T1_CLK:   return S_T1_LD;
            S_T1_LD:    return (k == K_BINARY) ? S_T2_SET : S_RES_SET;
            S_T2_SET:   return S_T2_CLK;
            S_T2_CLK:   return S_T2_LD;
            S_T2_LD:    return S_RES_SET;
            S_RES_SET:  return S_RES_CLK;
            S_PUSH_SET: return S_PUSH_CLK;
            S_POP_SET:  return S_POP_CLK;
            S_RES_CLK, S_PUSH_CLK, S_POP_CLK: return S_DONE;
            S_TRAP:     return S_TRAP;
            default:    return S_IDLE;
        endcase
    endfunction

    assign instr_kind = kind_e'(instr_if.instr[22:21]);
    assign accept     = instr_if.instr_valid & ctrl.instr_ready;

    always_comb begin
        legal = 1'b0;
        case (instr_kind)
            K_PUSH:   legal = (depth < DEPTH_MAX);
            K_BINARY: legal = (depth >= DEPTH_TWO);
            default:  legal = (depth != '0);
        endcase
    end

    // NOTE: nxt is given a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        nxt = state;
        if (state == S_IDLE) begin
            if (accept) begin
`ifdef PILHA_SEQ_TRAP_EN
                nxt = legal ? first_of(instr_kind) : S_TRAP;
`else
                nxt = first_of(instr_kind);
`endif
            end
        end else begin
            nxt = advance(state, kind);
        end
    end

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            ctrl         <= ctrl_of(S_IDLE);
            kind         <= K_PUSH;
            opcode       <= '0;
            din_UC       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            depth        <= '0;
            error        <= 1'b0;
        end else begin
            state        <= nxt;
            ctrl         <= ctrl_of(nxt);
            result_valid <= (nxt == S_DONE) && (kind == K_POP);
            if (accept) begin
                kind   <= instr_kind;
                opcode <= instr_if.instr[20:16];
                din_UC <= DATA_W'(instr_if.instr[15:0]);
                if (!legal) error <= 1'b1;
            end
            // Occupancy moves once per instruction, saturating at both ends.
            if (nxt == S_DONE) begin
                case (kind)
                    K_PUSH: if (depth != DEPTH_MAX) depth <= depth + DEPTH_W'(1);
                    K_BINARY, K_POP: if (depth != '0) depth <= depth - DEPTH_W'(1);
                    default: ;
                endcase
                if (kind == K_POP) result <= dout_dp;
            end
        end
    end

    assign instr_if.instr_ready = ctrl.instr_ready;
    assign push                 = ctrl.push;
    assign pop                  = ctrl.pop;
    assign controle_pilha       = ctrl.controle_pilha;
    assign load_temp1           = ctrl.load_temp1;
    assign load_temp2           = ctrl.load_temp2;
    assign clk_pilha            = ctrl.clk_pilha;
    assign clk_temp1            = ctrl.clk_temp1;
    assign clk_temp2            = ctrl.clk_temp2;
    assign done                 = ctrl.done;

endmodule
